// File: rtl/chip8_stack_pkg.sv
// Shared types for the Chip-8 return-address stack.
// The op encoding matches the 2-bit op port of chip8_call_stack.
package chip8_stack_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_t;

endpackage

// File: rtl/chip8_stack_mem.sv
// Storage array for the call stack: one synchronous write port and one asynchronous read port.
// The array has no reset, so its contents survive a stack reset.
module chip8_stack_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/chip8_call_stack.sv
// Parametrised LIFO return-address stack for the Chip-8 CPU.
// Provides a registered top-of-stack, replace-top, occupancy count and sticky error flags.
module chip8_call_stack
  import chip8_stack_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] writedata,
  input  logic              err_clear,
  output logic [DATA_W-1:0] outdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] top,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  stack_op_t         w_op;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_top;
  logic [DATA_W-1:0] r_outdata;
  logic              r_outValid;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_empty;
  logic              w_full;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [AW-1:0]     w_raddr;
  logic [DATA_W-1:0] w_rdata;

  assign w_op    = stack_op_t'(op);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // Entry below the current top, fetched ahead so a POP can refill top in one cycle.
  assign w_raddr = (r_count >= CW'(2)) ? AW'(r_count - CW'(2)) : '0;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = AW'(r_count);
    if (w_op == OP_PUSH && !w_full) begin
      w_we = 1'b1;
    end else if (w_op == OP_REPLACE && !w_empty) begin
      w_we    = 1'b1;
      w_waddr = AW'(r_count - CW'(1));
    end
  end

  chip8_stack_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk  (cpu_clk),
    .we   (w_we),
    .waddr(w_waddr),
    .wdata(writedata),
    .raddr(w_raddr),
    .rdata(w_rdata)
  );

  // Error flags are cleared first so that a same-cycle error event overrides the clear.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_top       <= '0;
      r_outdata   <= '0;
      r_outValid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      if (err_clear) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
      case (w_op)
        OP_PUSH: begin
          if (w_full) begin
            r_overflow <= 1'b1;
          end else begin
            r_count <= r_count + CW'(1);
            r_top   <= writedata;
          end
        end
        OP_POP: begin
          if (w_empty) begin
            r_underflow <= 1'b1;
          end else begin
            r_outdata  <= r_top;
            r_outValid <= 1'b1;
            r_count    <= r_count - CW'(1);
            r_top      <= (r_count == CW'(1)) ? '0 : w_rdata;
          end
        end
        OP_REPLACE: begin
          if (w_empty) r_underflow <= 1'b1;
          else         r_top       <= writedata;
        end
        default: ;
      endcase
    end
  end

  assign outdata   = r_outdata;
  assign out_valid = r_outValid;
  assign top       = r_top;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
